// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the data-memory arbiter and its read-tag pipe.
package dmem_arb_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic PORT_M0 = 1'b0;
  localparam logic PORT_M1 = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/arb_rd_tag_pipe.sv
// Shift pipe of {valid, id} tags that follows the memory read latency,
// so returning read data can be steered to the requester that issued it.
module arb_rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    CLK,
  input  logic    RST,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_q [DEPTH];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (M0) and a loader/DMA port (M1).
// Round-robin by default; define ARB_FIXED_PRIO_M0_EN to make M0 win every IDLE conflict.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  generate
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("dmem_arbiter: RD_LAT=%0d is outside %0d..%0d", RD_LAT, RD_LAT_MIN, RD_LAT_MAX);
    end
  endgenerate

  logic [0:0] state_q;
  logic [0:0] state_d;
  logic       owner_q;
  logic       owner_d;
  logic       req0;
  logic       req1;
  logic       pref;
  logic       win;
  logic       win_lock;
  logic       own_req;
  logic       own_lock;
  logic       gnt0;
  logic       gnt1;
  rd_tag_t    push_tag;
  rd_tag_t    ret_tag;

  // Masking requests with reset keeps every output low while reset is held.
  assign req0 = m0_req & RST;
  assign req1 = m1_req & RST;

`ifdef ARB_FIXED_PRIO_M0_EN
  assign pref = PORT_M0;
`else
  logic rr_ptr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rr_ptr <= PORT_M0;
    end else if (state_q == ST_IDLE && req0 && req1) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  assign pref = rr_ptr;
`endif

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    state_d  = state_q;
    owner_d  = owner_q;
    win      = PORT_M0;
    win_lock = 1'b0;
    own_req  = 1'b0;
    own_lock = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          win = pref;
        end else begin
          win = req1 ? PORT_M1 : PORT_M0;
        end
        win_lock = (win == PORT_M1) ? m1_lock : m0_lock;
        gnt0     = req0 && (win == PORT_M0);
        gnt1     = req1 && (win == PORT_M1);
        if ((gnt0 || gnt1) && win_lock) begin
          state_d = ST_LOCKED;
          owner_d = win;
        end
      end
      ST_LOCKED: begin
        // The owner's lock is honoured even without a request, idling the memory.
        own_req  = (owner_q == PORT_M1) ? req1 : req0;
        own_lock = (owner_q == PORT_M1) ? m1_lock : m0_lock;
        gnt0     = own_req && (owner_q == PORT_M0);
        gnt1     = own_req && (owner_q == PORT_M1);
        if (!own_lock) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      owner_q <= PORT_M0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  assign mem_we    = (gnt0 & m0_we) | (gnt1 & m1_we);
  assign mem_addr  = gnt0 ? m0_addr  : (gnt1 ? m1_addr  : '0);
  assign mem_wdata = gnt0 ? m0_wdata : (gnt1 ? m1_wdata : '0);

  assign push_tag.valid = (gnt0 & ~m0_we) | (gnt1 & ~m1_we);
  assign push_tag.id    = gnt1 ? PORT_M1 : PORT_M0;

  arb_rd_tag_pipe #(
    .DEPTH(RD_LAT)
  ) u_rd_tag_pipe (
    .CLK     (CLK),
    .RST     (RST),
    .tag_in  (push_tag),
    .tag_out (ret_tag)
  );

  assign m0_rvalid = ret_tag.valid && (ret_tag.id == PORT_M0);
  assign m1_rvalid = ret_tag.valid && (ret_tag.id == PORT_M1);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: three instances (RD_LAT=1,2,3) share one stimulus,
// each with its own latency-matched memory model.
module tb_dmem_arbiter;

`ifdef ARB_FIXED_PRIO_M0_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  localparam logic [31:0] WMASK = 32'h5A5A_0000;
  localparam logic [31:0] D40   = 32'hDEAD_BEEF;
  localparam logic [31:0] D10   = 32'h1111_0010;
  localparam logic [31:0] D20   = 32'h2222_0020;

  typedef struct packed {
    logic        req;
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        mwe;
    logic [31:0] maddr;
    logic        rv0;
    logic [31:0] rd0;
    logic        rv1;
    logic [31:0] rd1;
  } exp_t;

  typedef struct packed {
    req_t m0;
    req_t m1;
    exp_t e;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_gnt_v, m1_gnt_v, m0_rvalid_v, m1_rvalid_v, mem_we_v;
  logic [31:0] m0_rdata_v [3];
  logic [31:0] m1_rdata_v [3];
  logic [31:0] mem_addr_v [3];
  logic [31:0] mem_wdata_v [3];
  logic [31:0] mem_rdata_v [3];

  int   checks   = 0;
  int   failures = 0;
  req_t idle_r;
  exp_t zero_e;
  vec_t vecs [$];

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memModel(logic [31:0] a);
    case (a)
      32'h40:  return D40;
      32'h10:  return D10;
      32'h20:  return D20;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  generate
    for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int LAT = k + 1;
      logic [31:0] rd_pipe [LAT];

      dmem_arbiter #(
        .AW(32), .DW(32), .RD_LAT(LAT)
      ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt_v[k]),
        .m0_rvalid (m0_rvalid_v[k]),
        .m0_rdata  (m0_rdata_v[k]),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt_v[k]),
        .m1_rvalid (m1_rvalid_v[k]),
        .m1_rdata  (m1_rdata_v[k]),
        .mem_we    (mem_we_v[k]),
        .mem_addr  (mem_addr_v[k]),
        .mem_wdata (mem_wdata_v[k]),
        .mem_rdata (mem_rdata_v[k])
      );

      always @(posedge CLK) begin
        rd_pipe[0] <= memModel(mem_addr_v[k]);
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
      assign mem_rdata_v[k] = rd_pipe[LAT-1];
    end
  endgenerate

  function automatic req_t mkReq(logic req, logic we, logic lock, logic [31:0] addr);
    req_t r;
    r.req   = req;
    r.we    = we;
    r.lock  = lock;
    r.addr  = addr;
    r.wdata = req ? (addr ^ WMASK) : 32'h0;
    return r;
  endfunction

  function automatic exp_t mkExp(logic g0, logic g1, logic mwe, logic [31:0] maddr,
                                 logic rv0, logic [31:0] rd0, logic rv1, logic [31:0] rd1);
    exp_t e;
    e.g0 = g0; e.g1 = g1; e.mwe = mwe; e.maddr = maddr;
    e.rv0 = rv0; e.rd0 = rd0; e.rv1 = rv1; e.rd1 = rd1;
    return e;
  endfunction

  task automatic add_vec(req_t a, req_t b, exp_t e);
    vec_t v;
    v.m0 = a; v.m1 = b; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(req_t a, req_t b);
    m0_req = a.req; m0_we = a.we; m0_lock = a.lock; m0_addr = a.addr; m0_wdata = a.wdata;
    m1_req = b.req; m1_we = b.we; m1_lock = b.lock; m1_addr = b.addr; m1_wdata = b.wdata;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_vec(string tag, int k, exp_t e);
    logic [31:0] ewd;
    ewd = (e.g0 | e.g1) ? (e.maddr ^ WMASK) : 32'h0;
    checkOutput($sformatf("%s.%0d m0_gnt", tag, k),    {31'b0, m0_gnt_v[k]},    {31'b0, e.g0});
    checkOutput($sformatf("%s.%0d m1_gnt", tag, k),    {31'b0, m1_gnt_v[k]},    {31'b0, e.g1});
    checkOutput($sformatf("%s.%0d mem_we", tag, k),    {31'b0, mem_we_v[k]},    {31'b0, e.mwe});
    checkOutput($sformatf("%s.%0d mem_addr", tag, k),  mem_addr_v[k],           e.maddr);
    checkOutput($sformatf("%s.%0d mem_wdata", tag, k), mem_wdata_v[k],          ewd);
    checkOutput($sformatf("%s.%0d m0_rvalid", tag, k), {31'b0, m0_rvalid_v[k]}, {31'b0, e.rv0});
    checkOutput($sformatf("%s.%0d m0_rdata", tag, k),  m0_rdata_v[k],           e.rd0);
    checkOutput($sformatf("%s.%0d m1_rvalid", tag, k), {31'b0, m1_rvalid_v[k]}, {31'b0, e.rv1});
    checkOutput($sformatf("%s.%0d m1_rdata", tag, k),  m1_rdata_v[k],           e.rd1);
  endtask

  task automatic do_reset();
    applyStimulus(idle_r, idle_r);
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

  initial begin
    logic        rv0, rv1, eg0, eg1;
    logic [31:0] a0, a1;

    idle_r = mkReq(1'b0, 1'b0, 1'b0, 32'h0);
    zero_e = mkExp(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    add_vec(idle_r, idle_r, zero_e);
    add_vec(mkReq(1'b1, 1'b0, 1'b0, 32'h40), idle_r, mkExp(1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0));
    add_vec(idle_r, idle_r, mkExp(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, D40, 1'b0, 32'h0));
`ifndef ARB_FIXED_PRIO_M0_EN
    add_vec(mkReq(1'b1, 1'b1, 1'b0, 32'h100), mkReq(1'b1, 1'b1, 1'b0, 32'h200), mkExp(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0));
    add_vec(mkReq(1'b1, 1'b1, 1'b0, 32'h104), mkReq(1'b1, 1'b1, 1'b0, 32'h200), mkExp(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0));
    add_vec(mkReq(1'b1, 1'b1, 1'b0, 32'h104), mkReq(1'b1, 1'b1, 1'b0, 32'h204), mkExp(1'b1, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0));
    add_vec(mkReq(1'b1, 1'b1, 1'b0, 32'h108), mkReq(1'b1, 1'b1, 1'b0, 32'h204), mkExp(1'b0, 1'b1, 1'b1, 32'h204, 1'b0, 32'h0, 1'b0, 32'h0));
    add_vec(mkReq(1'b1, 1'b1, 1'b0, 32'h108), mkReq(1'b1, 1'b1, 1'b1, 32'h300), mkExp(1'b1, 1'b0, 1'b1, 32'h108, 1'b0, 32'h0, 1'b0, 32'h0));
    add_vec(mkReq(1'b1, 1'b1, 1'b0, 32'h10C), mkReq(1'b1, 1'b1, 1'b1, 32'h300), mkExp(1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0));
    add_vec(mkReq(1'b1, 1'b1, 1'b0, 32'h10C), mkReq(1'b1, 1'b1, 1'b1, 32'h304), mkExp(1'b0, 1'b1, 1'b1, 32'h304, 1'b0, 32'h0, 1'b0, 32'h0));
    add_vec(mkReq(1'b1, 1'b1, 1'b0, 32'h10C), mkReq(1'b1, 1'b1, 1'b1, 32'h308), mkExp(1'b0, 1'b1, 1'b1, 32'h308, 1'b0, 32'h0, 1'b0, 32'h0));
    add_vec(mkReq(1'b1, 1'b1, 1'b0, 32'h10C), mkReq(1'b1, 1'b1, 1'b0, 32'h30C), mkExp(1'b0, 1'b1, 1'b1, 32'h30C, 1'b0, 32'h0, 1'b0, 32'h0));
    add_vec(mkReq(1'b1, 1'b1, 1'b0, 32'h10C), idle_r, mkExp(1'b1, 1'b0, 1'b1, 32'h10C, 1'b0, 32'h0, 1'b0, 32'h0));
`endif
    add_vec(idle_r, mkReq(1'b1, 1'b0, 1'b0, 32'h20), mkExp(1'b0, 1'b1, 1'b0, 32'h20, 1'b0, 32'h0, 1'b0, 32'h0));
    add_vec(mkReq(1'b1, 1'b0, 1'b0, 32'h40), idle_r, mkExp(1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1, D20));
    add_vec(mkReq(1'b1, 1'b0, 1'b1, 32'h10), idle_r, mkExp(1'b1, 1'b0, 1'b0, 32'h10, 1'b1, D40, 1'b0, 32'h0));
    add_vec(mkReq(1'b0, 1'b0, 1'b1, 32'h0), mkReq(1'b1, 1'b1, 1'b0, 32'h210), mkExp(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, D10, 1'b0, 32'h0));
    add_vec(idle_r, mkReq(1'b1, 1'b1, 1'b0, 32'h210), zero_e);
    add_vec(idle_r, mkReq(1'b1, 1'b1, 1'b0, 32'h210), mkExp(1'b0, 1'b1, 1'b1, 32'h210, 1'b0, 32'h0, 1'b0, 32'h0));
    add_vec(idle_r, idle_r, zero_e);

    // Reset state, then requests held during reset must stay masked.
    applyStimulus(idle_r, idle_r);
    RST = 1'b0;
    @(negedge CLK);
    for (int k = 0; k < 3; k++) check_vec("reset", k, zero_e);
    applyStimulus(mkReq(1'b1, 1'b0, 1'b0, 32'h40), mkReq(1'b1, 1'b1, 1'b0, 32'h20));
    @(negedge CLK);
    for (int k = 0; k < 3; k++) check_vec("reset_req", k, zero_e);
    @(posedge CLK); #1;
    RST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].m0, vecs[i].m1);
      @(negedge CLK);
      check_vec($sformatf("vec%0d", i), 0, vecs[i].e);
      @(posedge CLK); #1;
    end

    // Interleaved reads: M0 granted at c0, M1 at c1; returns land LAT cycles later.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c == 0)      applyStimulus(mkReq(1'b1, 1'b0, 1'b0, 32'h10), mkReq(1'b1, 1'b0, 1'b0, 32'h20));
      else if (c == 1) applyStimulus(idle_r, mkReq(1'b1, 1'b0, 1'b0, 32'h20));
      else             applyStimulus(idle_r, idle_r);
      @(negedge CLK);
      checkOutput($sformatf("lat c%0d m0_gnt", c), {31'b0, m0_gnt_v[2]}, {31'b0, (c == 0)});
      checkOutput($sformatf("lat c%0d m1_gnt", c), {31'b0, m1_gnt_v[2]}, {31'b0, (c == 1)});
      for (int k = 0; k < 3; k++) begin
        rv0 = (c == k + 1);
        rv1 = (c == k + 2);
        checkOutput($sformatf("lat%0d c%0d m0_rvalid", k + 1, c), {31'b0, m0_rvalid_v[k]}, {31'b0, rv0});
        checkOutput($sformatf("lat%0d c%0d m0_rdata", k + 1, c),  m0_rdata_v[k], rv0 ? D10 : 32'h0);
        checkOutput($sformatf("lat%0d c%0d m1_rvalid", k + 1, c), {31'b0, m1_rvalid_v[k]}, {31'b0, rv1});
        checkOutput($sformatf("lat%0d c%0d m1_rdata", k + 1, c),  m1_rdata_v[k], rv1 ? D20 : 32'h0);
      end
      @(posedge CLK); #1;
    end

    // Reset one cycle after a locked conflict read: in-flight data, lock and rr_ptr all cleared.
    do_reset();
    applyStimulus(mkReq(1'b1, 1'b0, 1'b1, 32'h40), mkReq(1'b1, 1'b1, 1'b0, 32'h200));
    @(negedge CLK);
    checkOutput("pre_rst m0_gnt", {31'b0, m0_gnt_v[1]}, 32'h1);
    checkOutput("pre_rst m1_gnt", {31'b0, m1_gnt_v[1]}, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    applyStimulus(mkReq(1'b1, 1'b0, 1'b0, 32'h10), mkReq(1'b1, 1'b1, 1'b0, 32'h200));
    @(negedge CLK);
    for (int k = 0; k < 3; k++) check_vec("mid_rst", k, zero_e);
    @(posedge CLK); #1;
    RST = 1'b1;
    for (int r = 0; r < 5; r++) begin
      if (r == 0)      applyStimulus(idle_r, mkReq(1'b1, 1'b1, 1'b0, 32'h200));
      else if (r == 1) applyStimulus(mkReq(1'b1, 1'b0, 1'b0, 32'h10), mkReq(1'b1, 1'b1, 1'b0, 32'h204));
      else if (r == 2) applyStimulus(idle_r, mkReq(1'b1, 1'b1, 1'b0, 32'h204));
      else             applyStimulus(idle_r, idle_r);
      @(negedge CLK);
      checkOutput($sformatf("post_rst r%0d m0_gnt", r), {31'b0, m0_gnt_v[1]}, {31'b0, (r == 1)});
      checkOutput($sformatf("post_rst r%0d m1_gnt", r), {31'b0, m1_gnt_v[1]}, {31'b0, (r == 0 || r == 2)});
      for (int k = 0; k < 3; k++) begin
        rv0 = (r == k + 2);
        checkOutput($sformatf("post_rst%0d r%0d m0_rvalid", k + 1, r), {31'b0, m0_rvalid_v[k]}, {31'b0, rv0});
        checkOutput($sformatf("post_rst%0d r%0d m0_rdata", k + 1, r),  m0_rdata_v[k], rv0 ? D10 : 32'h0);
        checkOutput($sformatf("post_rst%0d r%0d m1_rvalid", k + 1, r), {31'b0, m1_rvalid_v[k]}, 32'h0);
      end
      @(posedge CLK); #1;
    end

    // Sustained write conflict; M0 drops its request in the last cycle.
    do_reset();
    a0 = 32'h500;
    a1 = 32'h600;
    for (int c = 0; c < 6; c++) begin
      applyStimulus((c < 5) ? mkReq(1'b1, 1'b1, 1'b0, a0) : idle_r, mkReq(1'b1, 1'b1, 1'b0, a1));
      eg0 = (c < 5) && (FIXED || (c % 2 == 0));
      eg1 = !eg0;
      @(negedge CLK);
      checkOutput($sformatf("conf c%0d m0_gnt", c),   {31'b0, m0_gnt_v[0]}, {31'b0, eg0});
      checkOutput($sformatf("conf c%0d m1_gnt", c),   {31'b0, m1_gnt_v[0]}, {31'b0, eg1});
      checkOutput($sformatf("conf c%0d mem_we", c),   {31'b0, mem_we_v[0]}, 32'h1);
      checkOutput($sformatf("conf c%0d mem_addr", c), mem_addr_v[0], eg0 ? a0 : a1);
      if (eg0) a0 = a0 + 32'h4;
      if (eg1) a1 = a1 + 32'h4;
      @(posedge CLK); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
